// File: rtl/ltc2324_pkg.sv
// Shared constants and types for the LTC2324 sample packer.
// Default channel geometry and the packer state encoding.
package ltc2324_pkg;

    localparam int CH_WIDTH      = 16;
    localparam int NUM_CH        = 4;
    localparam int WORDS_PER_SMP = NUM_CH / 2;

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } packer_state_t;

    typedef logic [CH_WIDTH-1:0] sample_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, valid, ready.
// The master drives tdata/tvalid and the slave drives tready.
interface axis_if #(
    parameter int DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through AXI-Stream read side.
// The head word is always presented on tdata while the FIFO is non-empty.
module axis_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    axis_if.master                m_axis,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;

    logic w_full;
    logic w_valid;
    logic w_wr;
    logic w_rd;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_valid = (r_level != '0);
    assign w_wr    = wr_en && !w_full;
    assign w_rd    = w_valid && m_axis.tready;

    assign m_axis.tdata  = r_mem[r_rd_ptr];
    assign m_axis.tvalid = w_valid;
    assign level         = r_level;

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: a simultaneous write and read leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            unique case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ltc2324_sample_packer.sv
// Packs LTC2324 conversions into channel-pair words and streams them out.
// Whole conversions are dropped and counted when buffer space is lacking.
module ltc2324_sample_packer #(
    parameter int CH_WIDTH   = ltc2324_pkg::CH_WIDTH,
    parameter int NUM_CH     = ltc2324_pkg::NUM_CH,
    parameter int DATA_WIDTH = 2 * ltc2324_pkg::CH_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic                          smp_valid,
    input  logic [NUM_CH*CH_WIDTH-1:0]    smp_data,
    axis_if.master                        m_axis,
    input  logic                          clr_ovf,
    output logic                          overflow,
    output logic [15:0]                   ovf_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import ltc2324_pkg::packer_state_t;
    import ltc2324_pkg::ST_IDLE;
    import ltc2324_pkg::ST_WRITE;

    localparam int W  = NUM_CH / 2;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = NUM_CH * CH_WIDTH;

    packer_state_t r_state;
    packer_state_t w_state_nxt;

    logic [SW-1:0]         r_hold;
    logic [IW-1:0]         r_word_idx;
    logic                  r_overflow;
    logic [15:0]           r_ovf_count;

    logic [LW-1:0]         w_level;
    logic                  w_req;
    logic                  w_space;
    logic                  w_capture;
    logic                  w_drop;
    logic                  w_last;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // Space is judged on the registered level; a read this cycle is not credited.
    assign w_req     = smp_valid && enable;
    assign w_space   = ({1'b0, w_level} + (LW+1)'(W)) <= (LW+1)'(FIFO_DEPTH);
    assign w_capture = (r_state == ST_IDLE) && w_req && w_space;
    assign w_drop    = w_req && !w_capture;
    assign w_last    = (r_word_idx == IW'(W - 1));

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: capture starts a write burst, last word ends it.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: one FIFO write per WRITE cycle, word k = {ch[2k+1], ch[2k]}.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = r_hold[r_word_idx*DATA_WIDTH +: DATA_WIDTH];
        unique case (r_state)
            ST_WRITE: w_wr_en = 1'b1;
            default:  w_wr_en = 1'b0;
        endcase
    end

    // Hold register and word index; dropped conversions leave the hold intact.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hold     <= '0;
            r_word_idx <= '0;
        end else if (w_capture) begin
            r_hold     <= smp_data;
            r_word_idx <= '0;
        end else if (r_state == ST_WRITE) begin
            r_word_idx <= w_last ? '0 : r_word_idx + IW'(1);
        end
    end

    // Sticky overflow and saturating drop count; a drop beats a clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_overflow  <= 1'b0;
            r_ovf_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf) begin
                r_ovf_count <= 16'd1;
            end else if (r_ovf_count != 16'hFFFF) begin
                r_ovf_count <= r_ovf_count + 16'd1;
            end
        end else if (clr_ovf) begin
            r_overflow  <= 1'b0;
            r_ovf_count <= '0;
        end
    end

    assign overflow   = r_overflow;
    assign ovf_count  = r_ovf_count;
    assign fifo_level = w_level;

    axis_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .m_axis  (m_axis),
        .level   (w_level)
    );

endmodule

// File: tb/tb_ltc2324_sample_packer.sv
// Scoreboard bench for ltc2324_sample_packer.
// Driver pushes expected words; a negedge monitor pops and compares.
module tb_ltc2324_sample_packer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        smp_valid;
    logic [63:0] smp_data;
    logic        clr_ovf;
    logic        overflow;
    logic [15:0] ovf_count;
    logic [4:0]  fifo_level;

    axis_if #(.DATA_WIDTH(32)) axis ();

    ltc2324_sample_packer #(
        .CH_WIDTH   (16),
        .NUM_CH     (4),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (16)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     (enable),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .m_axis     (axis),
        .clr_ovf    (clr_ovf),
        .overflow   (overflow),
        .ovf_count  (ovf_count),
        .fifo_level (fifo_level)
    );

    always #5 aclk = ~aclk;

    logic [31:0] sb [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          m_chk = 0;
    int          m_pass = 0;
    bit          rnd_ready = 1'b0;
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_w;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
        if (rnd_ready)
            axis.tready = cyc[0] | 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] c0, input logic [15:0] c1,
                        input logic [15:0] c2, input logic [15:0] c3,
                        input bit acc);
        smp_data  = {c3, c2, c1, c0};
        smp_valid = 1'b1;
        if (acc) begin
            sb.push_back({c1, c0});
            sb.push_back({c3, c2});
        end
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    // Monitor: output order, no extra words, stability while stalled.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                m_chk++;
                if (axis.tvalid === 1'b1 && axis.tdata === prev_data)
                    m_pass++;
                else
                    $display("FAIL stall_hold: tvalid=%b tdata=%h want 1 %h",
                             axis.tvalid, axis.tdata, prev_data);
            end
            if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
                m_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL extra_word: got %h want none", axis.tdata);
                end else begin
                    exp_w = sb.pop_front();
                    if (axis.tdata === exp_w) m_pass++;
                    else $display("FAIL word: got %h want %h",
                                  axis.tdata, exp_w);
                end
            end
            prev_stall = (axis.tvalid === 1'b1) && (axis.tready === 1'b0);
            prev_data  = axis.tdata;
        end
    end

    initial begin
        aresetn     = 1'b0;
        enable      = 1'b1;
        smp_valid   = 1'b0;
        smp_data    = '0;
        clr_ovf     = 1'b0;
        axis.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;

        check("rst_tvalid", 32'(axis.tvalid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        tick();

        // Single conversion and latency
        send(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
        check("t1_tvalid_capture", 32'(axis.tvalid), 32'd0);
        tick();
        check("t1_tvalid_n1", 32'(axis.tvalid), 32'd1);
        check("t1_tdata_n1", axis.tdata, 32'h2222_1111);
        check("t1_level_n1", 32'(fifo_level), 32'd1);
        repeat (3) tick();
        check("t1_tvalid_end", 32'(axis.tvalid), 32'd0);
        check("t1_ovf_count", 32'(ovf_count), 32'd0);

        // Backpressure: 10 conversions, 8 fit
        axis.tready = 1'b0;
        clr_pulse();
        for (int i = 0; i < 10; i++) begin
            send(16'(16'h2000 + i*4), 16'(16'h2001 + i*4),
                 16'(16'h2002 + i*4), 16'(16'h2003 + i*4), i < 8);
            repeat (3) tick();
        end
        check("t2_level_full", 32'(fifo_level), 32'd16);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_ovf_count", 32'(ovf_count), 32'd2);
        check("t2_head", axis.tdata, 32'h2001_2000);
        axis.tready = 1'b1;
        repeat (17) tick();
        check("t2_tvalid_drained", 32'(axis.tvalid), 32'd0);
        check("t2_level_drained", 32'(fifo_level), 32'd0);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Back-to-back strobes
        clr_pulse();
        smp_valid = 1'b1;
        smp_data  = 64'hA004_A003_A002_A001;
        sb.push_back(32'hA002_A001);
        sb.push_back(32'hA004_A003);
        tick();
        smp_data = 64'hB004_B003_B002_B001;
        tick();
        smp_valid = 1'b0;
        repeat (4) tick();
        check("t3_ovf_count", 32'(ovf_count), 32'd1);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);
        check("t3_level", 32'(fifo_level), 32'd0);

        // Randomised tready with continuous input
        clr_pulse();
        rnd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(16'(16'h4000 + i*4), 16'(16'h4001 + i*4),
                 16'(16'h4002 + i*4), 16'(16'h4003 + i*4), 1'b1);
            repeat (3) tick();
        end
        rnd_ready   = 1'b0;
        axis.tready = 1'b1;
        repeat (10) tick();
        check("t4_ovf_count", 32'(ovf_count), 32'd0);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during WRITE after word0
        axis.tready = 1'b0;
        send(16'h5001, 16'h5002, 16'h5003, 16'h5004, 1'b0);
        tick();
        check("t5_level_pre", 32'(fifo_level), 32'd1);
        #1;
        aresetn = 1'b0;
        #1;
        check("t5_tvalid_rst", 32'(axis.tvalid), 32'd0);
        check("t5_level_rst", 32'(fifo_level), 32'd0);
        tick();
        aresetn     = 1'b1;
        axis.tready = 1'b1;
        repeat (4) tick();
        check("t5_no_stale", 32'(axis.tvalid), 32'd0);
        send(16'h6001, 16'h6002, 16'h6003, 16'h6004, 1'b1);
        repeat (4) tick();
        check("t5_sb_empty", 32'(sb.size()), 32'd0);
        check("t5_level_end", 32'(fifo_level), 32'd0);

        // Counter clear, coincident drop, saturation
        axis.tready = 1'b0;
        clr_pulse();
        for (int i = 0; i < 8; i++) begin
            send(16'(16'h7000 + i*4), 16'(16'h7001 + i*4),
                 16'(16'h7002 + i*4), 16'(16'h7003 + i*4), 1'b1);
            repeat (3) tick();
        end
        check("t6_level_full", 32'(fifo_level), 32'd16);
        send(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b0);
        send(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0);
        check("t6_ovf_count_2", 32'(ovf_count), 32'd2);
        smp_valid = 1'b1;
        clr_ovf   = 1'b1;
        tick();
        clr_ovf = 1'b0;
        smp_valid = 1'b0;
        check("t6_clr_drop_ovf", 32'(overflow), 32'd1);
        check("t6_clr_drop_cnt", 32'(ovf_count), 32'd1);
        smp_valid = 1'b1;
        repeat (65536) tick();
        smp_valid = 1'b0;
        check("t6_sat_cnt", 32'(ovf_count), 32'h0000_FFFF);
        check("t6_sat_ovf", 32'(overflow), 32'd1);
        clr_pulse();
        check("t6_clr_cnt", 32'(ovf_count), 32'd0);
        check("t6_clr_ovf", 32'(overflow), 32'd0);
        axis.tready = 1'b1;
        repeat (20) tick();
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        check("t6_level_end", 32'(fifo_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass + m_pass, n_chk + m_chk);
        $finish;
    end

endmodule
